// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM initiator controller and the SRAM instance it drives.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_DEPTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_RSP  = 3'd4,
    S_INIT = 3'd5
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port SRAM initiator: one SRAM access per request, read data returned on a valid/ready channel.
// Optional power-up fill sweep enabled by defining SRAM_CTRL_INIT_EN.
//
//   state | meaning
//   IDLE  | ready for a request
//   WR    | SRAM write strobe asserted
//   RD    | SRAM read strobe asserted
//   CAP   | capture registered SRAM read data
//   RSP   | response held until rsp_ready
//   INIT  | fill sweep writing INIT_VALUE (SRAM_CTRL_INIT_EN only)
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int              ADDR       = SRAM_ADDR_W,
  parameter int              DATA       = SRAM_DATA_W,
  parameter int              DEPTH      = SRAM_DEPTH,
  parameter logic [DATA-1:0] INIT_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            wr_err,
  output logic            init_busy,
  output logic            sram_cs,
  output logic            sram_we,
  output logic            sram_rd,
  output logic [ADDR-1:0] sram_addr,
  output logic [DATA-1:0] sram_din,
  input  logic [DATA-1:0] sram_dout
);

  localparam logic [ADDR:0] DEPTH_X = (ADDR+1)'(DEPTH);

  state_t          state, state_nx;
  logic            addr_ok;
  logic            cs_nx, we_nx, rd_nx;
  logic [ADDR-1:0] addr_nx;
  logic [DATA-1:0] din_nx, rdata_nx;
  logic            rvalid_nx, rerr_nx, wr_err_nx;

`ifdef SRAM_CTRL_INIT_EN
  localparam state_t RST_STATE = S_INIT;
  logic [ADDR:0] init_cnt;
  logic          init_run;

  assign init_run = (state == S_INIT) && (init_cnt != DEPTH_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt  <= '0;
      init_busy <= 1'b0;
    end else begin
      init_busy <= init_run;
      if (init_run) init_cnt <= init_cnt + 1'b1;
    end
  end
`else
  localparam state_t RST_STATE = S_IDLE;
  logic unused_init;

  assign unused_init = ^INIT_VALUE;
  assign init_busy   = 1'b0;
`endif

  assign addr_ok = {1'b0, req_addr} < DEPTH_X;
  // Held low during reset so nothing can look accepted while rst is asserted.
  assign req_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      sram_cs   <= cs_nx;
      sram_we   <= we_nx;
      sram_rd   <= rd_nx;
      sram_addr <= addr_nx;
      sram_din  <= din_nx;
      rsp_valid <= rvalid_nx;
      rsp_rdata <= rdata_nx;
      rsp_err   <= rerr_nx;
      wr_err    <= wr_err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) state_nx = addr_ok ? S_WR : S_IDLE;
          else        state_nx = addr_ok ? S_RD : S_RSP;
        end
      end
      S_WR:  state_nx = S_IDLE;
      S_RD:  state_nx = S_CAP;
      S_CAP: state_nx = S_RSP;
      S_RSP: if (rsp_ready) state_nx = S_IDLE;
`ifdef SRAM_CTRL_INIT_EN
      S_INIT: if (init_cnt == DEPTH_X) state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Strobes are single-cycle pulses; everything else holds unless a state updates it.
  always_comb begin
    cs_nx     = 1'b0;
    we_nx     = 1'b0;
    rd_nx     = 1'b0;
    addr_nx   = sram_addr;
    din_nx    = sram_din;
    rvalid_nx = rsp_valid;
    rdata_nx  = rsp_rdata;
    rerr_nx   = rsp_err;
    wr_err_nx = wr_err;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            if (addr_ok) begin
              addr_nx = req_addr;
              din_nx  = req_wdata;
              cs_nx   = 1'b1;
              we_nx   = 1'b1;
            end else begin
              wr_err_nx = 1'b1;
            end
          end else if (addr_ok) begin
            addr_nx = req_addr;
            cs_nx   = 1'b1;
            rd_nx   = 1'b1;
          end else begin
            rvalid_nx = 1'b1;
            rerr_nx   = 1'b1;
            rdata_nx  = '0;
          end
        end
      end
      S_CAP: begin
        rdata_nx  = sram_dout;
        rerr_nx   = 1'b0;
        rvalid_nx = 1'b1;
      end
      S_RSP: if (rsp_ready) rvalid_nx = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
      S_INIT: begin
        if (init_run) begin
          cs_nx   = 1'b1;
          we_nx   = 1'b1;
          addr_nx = init_cnt[ADDR-1:0];
          din_nx  = INIT_VALUE;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, directed corner sequences and randomized traffic
// against a word-array reference model. Also covers the SRAM_CTRL_INIT_EN sweep when that macro is defined.
module tb_sram_ctrl;

  localparam int         DEP    = 8;
  localparam logic [7:0] INIT_V = 8'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err, wr_err, init_busy;
  logic       sram_cs, sram_we, sram_rd;
  logic [7:0] rsp_rdata, sram_addr, sram_din, sram_dout;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR(8), .DATA(8), .DEPTH(DEP), .INIT_VALUE(INIT_V)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_err(wr_err), .init_busy(init_busy),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural synchronous SRAM with registered read data.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
    if (sram_cs && sram_rd) sram_dout <= mem[sram_addr];
  end

  int n_checks = 0, n_fail = 0, cs_cnt = 0, cyc = 0;
  int wlog_addr[$];
  int wlog_cyc[$];
  logic [7:0] ref_mem [DEP];
  logic       ref_wr_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_exclusive", 32'(sram_we & sram_rd), 32'd0);
      chk("cs_with_strobe", 32'((sram_we | sram_rd) & ~sram_cs), 32'd0);
      if (sram_cs) cs_cnt++;
      if (sram_cs && sram_we) begin
        wlog_addr.push_back(int'(sram_addr));
        wlog_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    if (a < DEP) ref_mem[a[2:0]] = d;
    else ref_wr_err = 1'b1;
  endtask

  // lat = clock edge (counted from the handshake edge) at which the consumer first samples rsp_valid=1.
  task automatic do_read(input logic [7:0] a, input int stall,
                         output logic [7:0] rd, output logic er, output int lat);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    rsp_ready = (stall == 0);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < stall; i++) tick();
    rsp_ready = 1'b1;
    tick();
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_wr_err;
    int         exp_lat;
    int         exp_cs;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] rd;
  logic       er;
  int         lat, cs0, busy;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we    addr   wdata  rdata  err   wr_err lat cs
    tbl[0] = '{1'b1, 8'd3,   8'hA5, 8'h00, 1'b0, 1'b0, 0, 1};
    tbl[1] = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 1'b0, 3, 1};
    tbl[2] = '{1'b1, 8'd7,   8'h5A, 8'h00, 1'b0, 1'b0, 0, 1};
    tbl[3] = '{1'b0, 8'd7,   8'h00, 8'h5A, 1'b0, 1'b0, 3, 1};
    tbl[4] = '{1'b0, 8'd8,   8'h00, 8'h00, 1'b1, 1'b0, 1, 0};
    tbl[5] = '{1'b1, 8'd0,   8'hC3, 8'h00, 1'b0, 1'b0, 0, 1};
    tbl[6] = '{1'b0, 8'd0,   8'h00, 8'hC3, 1'b0, 1'b0, 3, 1};
    tbl[7] = '{1'b0, 8'd255, 8'h00, 8'h00, 1'b1, 1'b0, 1, 0};
    tbl[8] = '{1'b1, 8'd200, 8'h77, 8'h00, 1'b0, 1'b1, 0, 0};
    tbl[9] = '{1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 1'b1, 3, 1};

    // Reset state
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", {21'd0, rsp_valid, rsp_err, wr_err, init_busy, sram_cs, sram_we, sram_rd, 4'd0}, 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_din", 32'(sram_din), 32'd0);
    for (int i = 0; i < DEP; i++) ref_mem[i] = 8'h00;
    rst = 1'b0;

`ifdef SRAM_CTRL_INIT_EN
    for (int i = 0; i < DEP; i++) ref_mem[i] = INIT_V;
    wlog_addr.delete(); wlog_cyc.delete();
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (init_busy) begin
        busy++;
        chk("init_req_ready_low", 32'(req_ready), 32'd0);
      end
    end
    chk("init_busy_cycles", 32'(busy), 32'(DEP));
    chk("init_write_count", 32'(wlog_addr.size()), 32'(DEP));
    for (int i = 0; i < DEP && i < wlog_addr.size(); i++) chk("init_write_addr", 32'(wlog_addr[i]), 32'(i));
    for (int i = 0; i < DEP; i++) begin
      do_read(8'(i), 0, rd, er, lat);
      chk("init_readback", 32'(rd), 32'(INIT_V));
    end
`else
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("no_init_busy", 32'(init_busy), 32'd0);
`endif

    // Vector table
    for (int i = 0; i < 10; i++) begin
      cs0 = cs_cnt;
      if (tbl[i].we) begin
        do_write(tbl[i].addr, tbl[i].wdata);
      end else begin
        do_read(tbl[i].addr, 0, rd, er, lat);
        chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
        chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      end
      tick();
      chk($sformatf("tbl%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].exp_wr_err));
      chk($sformatf("tbl%0d_cs_cycles", i), 32'(cs_cnt - cs0), 32'(tbl[i].exp_cs));
    end

    // Write strobe shape and occupancy
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd3; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_strobes", {29'd0, sram_cs, sram_we, sram_rd}, 32'b110);
    chk("wr_addr", 32'(sram_addr), 32'd3);
    chk("wr_din", 32'(sram_din), 32'hA5);
    chk("wr_busy_ready", 32'(req_ready), 32'd0);
    tick();
    chk("wr_strobe_drop", {30'd0, sram_cs, sram_we}, 32'd0);
    chk("wr_done_ready", 32'(req_ready), 32'd1);

    // Backpressure
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    busy = 0;
    while (!rsp_valid && busy < 20) begin tick(); busy++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", 32'(rsp_rdata), 32'hA5);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(req_ready), 32'd1);
    chk("bp_rdata_kept", 32'(rsp_rdata), 32'hA5);

    // Back-to-back writes, then read back
    wlog_addr.delete(); wlog_cyc.delete();
    for (int i = 0; i < 8; i++) do_write(8'(i), 8'(8'h10 + i));
    tick();
    chk("b2b_write_count", 32'(wlog_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < wlog_addr.size(); i++) begin
      chk("b2b_write_addr", 32'(wlog_addr[i]), 32'(i));
      if (i > 0) chk("b2b_spacing", 32'(wlog_cyc[i] - wlog_cyc[i-1]), 32'd2);
    end
    for (int i = 0; i < 8; i++) begin
      do_read(8'(i), 0, rd, er, lat);
      chk("b2b_readback", 32'(rd), 32'(8'h10 + i));
      chk("b2b_err", 32'(er), 32'd0);
    end
    chk("wr_err_sticky", 32'(wr_err), 32'd1);

    // Reset in the RD cycle
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
    tick();
    req_valid = 1'b0;
    chk("rdrst_rd_strobe", 32'(sram_rd), 32'd1);
    rst = 1'b1;
    tick();
    chk("rdrst_strobes", {29'd0, sram_cs, sram_we, sram_rd}, 32'd0);
    chk("rdrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rdrst_wr_err", 32'(wr_err), 32'd0);
    rst = 1'b0;
    ref_wr_err = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
    for (int i = 0; i < DEP; i++) ref_mem[i] = INIT_V;
`endif
    tick();
    chk("rdrst_no_stale_rsp", 32'(rsp_valid), 32'd0);
    do_read(8'd5, 0, rd, er, lat);
    chk("rdrst_read5", 32'(rd), 32'(ref_mem[5]));
    chk("rdrst_read5_lat", 32'(lat), 32'd3);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a, d;
      int st;
      a  = ($urandom_range(0, 9) == 0) ? 8'(8 + $urandom_range(0, 247)) : 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      st = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d);
      end else begin
        do_read(a, st, rd, er, lat);
        chk("rand_rdata", 32'(rd), (a < DEP) ? 32'(ref_mem[a[2:0]]) : 32'd0);
        chk("rand_err", 32'(er), 32'(a >= DEP));
        chk("rand_latency", 32'(lat), (a < DEP) ? 32'd3 : 32'd1);
      end
      chk("rand_wr_err", 32'(wr_err), 32'(ref_wr_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
